wb_gpio_irq: RTL

WB_GPIO_IRQ -- requirements
Module: wb_gpio_irq

---
 rtl/wb_gpio_pkg.sv | 57 +++++
 rtl/gpio_sync_edge.sv | 48 ++++
 rtl/wb_gpio_irq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/wb_gpio_pkg.sv
// Shared register map, bus payload type and helpers for the Wishbone GPIO block.
package wb_gpio_pkg;

    localparam int unsigned WB_DATA_W      = 32;
    localparam int unsigned WB_ADDR_W      = 32;
    localparam int unsigned WB_SEL_W       = 4;
    localparam int unsigned GPIO_MAX_WIDTH = 32;

    localparam logic [WB_ADDR_W-1:0] ADDR_IO         = 32'd0;
    localparam logic [WB_ADDR_W-1:0] ADDR_DIR        = 32'd1;
    localparam logic [WB_ADDR_W-1:0] ADDR_INT_EN     = 32'd2;
    localparam logic [WB_ADDR_W-1:0] ADDR_INT_EDGE   = 32'd3;
    localparam logic [WB_ADDR_W-1:0] ADDR_INT_STATUS = 32'd4;
    localparam logic [WB_ADDR_W-1:0] ADDR_INT_BOTH   = 32'd5;

    typedef enum logic [2:0] {
        REG_IO         = 3'd0,
        REG_DIR        = 3'd1,
        REG_INT_EN     = 3'd2,
        REG_INT_EDGE   = 3'd3,
        REG_INT_STATUS = 3'd4,
        REG_INT_BOTH   = 3'd5,
        REG_NONE       = 3'd7
    } reg_sel_e;

    typedef struct packed {
        logic                 we;
        logic [WB_SEL_W-1:0]  sel;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
    } wb_req_t;

    function automatic reg_sel_e decode_addr(input logic [WB_ADDR_W-1:0] adr);
        reg_sel_e sel;
        case (adr)
            ADDR_IO:         sel = REG_IO;
            ADDR_DIR:        sel = REG_DIR;
            ADDR_INT_EN:     sel = REG_INT_EN;
            ADDR_INT_EDGE:   sel = REG_INT_EDGE;
            ADDR_INT_STATUS: sel = REG_INT_STATUS;
            ADDR_INT_BOTH:   sel = REG_INT_BOTH;
            default:         sel = REG_NONE;
        endcase
        return sel;
    endfunction

    // Expand byte enables into a per-bit write mask.
    function automatic logic [WB_DATA_W-1:0] lane_mask(input logic [WB_SEL_W-1:0] sel);
        logic [WB_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(WB_SEL_W); i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchronizer, history flop and rise/fall detection.
// Edges are suppressed until the pipeline has filled after reset release.
module gpio_sync_edge #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_c_o,
    output logic [WIDTH-1:0] fall_c_o
);

    localparam int unsigned FILL_W    = 3;
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(STAGES + 1);

    logic [WIDTH-1:0]  sync_q [STAGES];
    logic [WIDTH-1:0]  hist_q;
    logic [FILL_W-1:0] fill_q;
    logic              primed;

    assign primed = (fill_q == FILL_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q[0] <= pin_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[STAGES-1];
            if (!primed) begin
                fill_q <= fill_q + FILL_W'(1);
            end
        end
    end

    assign sync_o   = sync_q[STAGES-1];
    assign rise_c_o = primed ? (sync_q[STAGES-1] & ~hist_q) : '0;
    assign fall_c_o = primed ? (~sync_q[STAGES-1] & hist_q) : '0;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone-attached GPIO with per-pin edge interrupts and sticky W1C status.
// Define WB_GPIO_BOTH_EDGE_EN to enable the INT_BOTH (either-edge) register.
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wbs_we_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic [31:0]           wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  wbs_int_o,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe
);

    wb_req_t               req_c;
    reg_sel_e              reg_c;
    logic                  launch_c;
    logic [WB_DATA_W-1:0]  lane_c;
    logic [GPIO_WIDTH-1:0] wmask_c;
    logic [GPIO_WIDTH-1:0] wdata_c;
    logic [GPIO_WIDTH-1:0] w1c_c;
    logic [GPIO_WIDTH-1:0] hit_c;
    logic [GPIO_WIDTH-1:0] both_c;
    logic [GPIO_WIDTH-1:0] rd_c;

    logic [GPIO_WIDTH-1:0] sync_in;
    logic [GPIO_WIDTH-1:0] rise_c;
    logic [GPIO_WIDTH-1:0] fall_c;

    logic [GPIO_WIDTH-1:0] out_q,    out_d;
    logic [GPIO_WIDTH-1:0] dir_q,    dir_d;
    logic [GPIO_WIDTH-1:0] en_q,     en_d;
    logic [GPIO_WIDTH-1:0] edge_q,   edge_d;
    logic [GPIO_WIDTH-1:0] status_q, status_d;
    logic [WB_DATA_W-1:0]  dat_q,    dat_d;
    logic                  ack_q,    ack_d;
    logic                  int_q,    int_d;

`ifdef WB_GPIO_BOTH_EDGE_EN
    logic [GPIO_WIDTH-1:0] both_q, both_d;
    assign both_c = both_q;
`else
    assign both_c = '0;
`endif

    gpio_sync_edge #(
        .WIDTH  (GPIO_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .pin_i    (gpio_in),
        .sync_o   (sync_in),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    assign req_c = '{we: wbs_we_i, sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};

    // A transfer is serviced only on the cycle its ack is launched.
    assign launch_c = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign reg_c    = decode_addr(req_c.adr);
    assign lane_c   = lane_mask(req_c.sel);
    assign wmask_c  = lane_c[GPIO_WIDTH-1:0];
    assign wdata_c  = req_c.dat[GPIO_WIDTH-1:0];

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        en_d   = en_q;
        edge_d = edge_q;
        w1c_c  = '0;
`ifdef WB_GPIO_BOTH_EDGE_EN
        both_d = both_q;
`endif
        if (launch_c && req_c.we) begin
            case (reg_c)
                REG_IO:         out_d  = (out_q  & ~wmask_c) | (wdata_c & wmask_c);
                REG_DIR:        dir_d  = (dir_q  & ~wmask_c) | (wdata_c & wmask_c);
                REG_INT_EN:     en_d   = (en_q   & ~wmask_c) | (wdata_c & wmask_c);
                REG_INT_EDGE:   edge_d = (edge_q & ~wmask_c) | (wdata_c & wmask_c);
                REG_INT_STATUS: w1c_c  = wdata_c & wmask_c;
`ifdef WB_GPIO_BOTH_EDGE_EN
                REG_INT_BOTH:   both_d = (both_q & ~wmask_c) | (wdata_c & wmask_c);
`endif
                default: ;
            endcase
        end
    end

    // New edges are OR-ed in after the clear so a colliding edge survives W1C.
    always_comb begin
        hit_c    = (rise_c & edge_q) | (fall_c & ~edge_q) | ((rise_c | fall_c) & both_c);
        status_d = (status_q & ~w1c_c) | hit_c;
        int_d    = |(status_q & en_q);
        ack_d    = launch_c;
    end

    always_comb begin
        rd_c = '0;
        case (reg_c)
            REG_IO:         rd_c = (sync_in & ~dir_q) | (out_q & dir_q);
            REG_DIR:        rd_c = dir_q;
            REG_INT_EN:     rd_c = en_q;
            REG_INT_EDGE:   rd_c = edge_q;
            REG_INT_STATUS: rd_c = status_q;
            REG_INT_BOTH:   rd_c = both_c;
            default:        rd_c = '0;
        endcase
        dat_d = dat_q;
        if (launch_c && !req_c.we) begin
            dat_d = WB_DATA_W'(rd_c);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= '0;
            dir_q    <= '0;
            en_q     <= '0;
            edge_q   <= '0;
            status_q <= '0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            int_q    <= 1'b0;
`ifdef WB_GPIO_BOTH_EDGE_EN
            both_q   <= '0;
`endif
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            en_q     <= en_d;
            edge_q   <= edge_d;
            status_q <= status_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            int_q    <= int_d;
`ifdef WB_GPIO_BOTH_EDGE_EN
            both_q   <= both_d;
`endif
        end
    end

    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_int_o = int_q;
    assign gpio_out  = out_q;
    assign gpio_oe   = dir_q;

endmodule
